// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with frame-synchronous, clamped pointer output.
// Every output is registered from the next-state values, so strobes track counters.
module vga_timing_gen #(
  parameter int H_ACTIVE = 800,
  parameter int H_FP     = 40,
  parameter int H_SYNC   = 128,
  parameter int H_BP     = 88,
  parameter int V_ACTIVE = 600,
  parameter int V_FP     = 1,
  parameter int V_SYNC   = 4,
  parameter int V_BP     = 23,
  parameter int PTR_W    = 10,
  parameter int PTR_H    = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] x_pointer_in,
  input  logic [10:0] y_pointer_in,
  input  logic        ptr_valid,
  output logic [10:0] hcount_out,
  output logic [10:0] vcount_out,
  output logic        hsync_out,
  output logic        vsync_out,
  output logic        hblnk_out,
  output logic        vblnk_out,
  output logic [10:0] x_pointer,
  output logic [10:0] y_pointer,
  output logic        frame_start,
  output logic [15:0] frame_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST  = 11'(V_TOTAL - 1);
  localparam logic [10:0] HB_ON   = 11'(H_ACTIVE);
  localparam logic [10:0] HS_ON   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_OFF  = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VB_ON   = 11'(V_ACTIVE);
  localparam logic [10:0] VS_ON   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_OFF  = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [10:0] X_MAX   = 11'(H_ACTIVE - 1 - PTR_W);
  localparam logic [10:0] Y_MAX   = 11'(V_ACTIVE - 1 - PTR_H);

  logic [10:0] h_next;
  logic [10:0] v_next;
  logic        h_wrap;
  logic        origin;
  logic [10:0] pend_x;
  logic [10:0] pend_y;
  logic [10:0] src_x;
  logic [10:0] src_y;
  logic [10:0] clamp_x;
  logic [10:0] clamp_y;

  always_comb begin
    h_wrap = (hcount_out == H_LAST);
    h_next = h_wrap ? 11'd0 : hcount_out + 11'd1;
    v_next = vcount_out;
    if (h_wrap)
      v_next = (vcount_out == V_LAST) ? 11'd0 : vcount_out + 11'd1;
    origin = h_wrap && (vcount_out == V_LAST);
  end

  // A valid in the wrap cycle bypasses the pending register.
  always_comb begin
    src_x   = ptr_valid ? x_pointer_in : pend_x;
    src_y   = ptr_valid ? y_pointer_in : pend_y;
    clamp_x = (src_x > X_MAX) ? X_MAX : src_x;
    clamp_y = (src_y > Y_MAX) ? Y_MAX : src_y;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hcount_out  <= '0;
      vcount_out  <= '0;
      hsync_out   <= 1'b0;
      vsync_out   <= 1'b0;
      hblnk_out   <= 1'b0;
      vblnk_out   <= 1'b0;
      pend_x      <= '0;
      pend_y      <= '0;
      x_pointer   <= '0;
      y_pointer   <= '0;
      frame_start <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      hcount_out  <= h_next;
      vcount_out  <= v_next;
      hblnk_out   <= (h_next >= HB_ON);
      hsync_out   <= (h_next >= HS_ON) && (h_next < HS_OFF);
      vblnk_out   <= (v_next >= VB_ON);
      vsync_out   <= (v_next >= VS_ON) && (v_next < VS_OFF);
      frame_start <= origin;
      if (ptr_valid) begin
        pend_x <= x_pointer_in;
        pend_y <= y_pointer_in;
      end
      if (origin) begin
        x_pointer <= clamp_x;
        y_pointer <= clamp_y;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: reduced raster, random pointer traffic, directed cases.
// Expected values come from cycle-index arithmetic and a frame-level pointer model.
module tb_vga_timing_gen;

  localparam int HA = 40, HF = 4, HS = 8, HB = 6;
  localparam int VA = 20, VF = 1, VS = 3, VB = 4;
  localparam int PW = 10, PH = 13;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;
  localparam int XMAX = HA - 1 - PW;
  localparam int YMAX = VA - 1 - PH;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [10:0] x_pointer_in = '0;
  logic [10:0] y_pointer_in = '0;
  logic        ptr_valid = 1'b0;
  logic [10:0] hcount_out, vcount_out;
  logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
  logic [10:0] x_pointer, y_pointer;
  logic        frame_start;
  logic [15:0] frame_cnt;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .PTR_W(PW), .PTR_H(PH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .x_pointer_in(x_pointer_in),
    .y_pointer_in(y_pointer_in),
    .ptr_valid(ptr_valid),
    .hcount_out(hcount_out),
    .vcount_out(vcount_out),
    .hsync_out(hsync_out),
    .vsync_out(vsync_out),
    .hblnk_out(hblnk_out),
    .vblnk_out(vblnk_out),
    .x_pointer(x_pointer),
    .y_pointer(y_pointer),
    .frame_start(frame_start),
    .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  longint t = 0;
  int     pend_x = 0, pend_y = 0;
  int     mx = 0, my = 0, mfc = 0;
  int     mfs = 0;

  task automatic chk(input string tag, input longint obs, input longint expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  function automatic int lim(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic step(input bit r, input bit pv, input int px, input int py);
    int h, v, hs, vs, hb, vb;
    rst = r;
    ptr_valid = pv;
    x_pointer_in = 11'(px);
    y_pointer_in = 11'(py);
    @(posedge clk);
    if (r) begin
      t = 0; pend_x = 0; pend_y = 0;
      mx = 0; my = 0; mfc = 0; mfs = 0;
    end else begin
      t++;
      mfs = 0;
      if (t % FRAME == 0) begin
        mx = lim(pv ? px : pend_x, XMAX);
        my = lim(pv ? py : pend_y, YMAX);
        mfc = (mfc + 1) % 65536;
        mfs = 1;
      end
      if (pv) begin
        pend_x = px;
        pend_y = py;
      end
    end
    @(negedge clk);
    h  = int'(t % HT);
    v  = int'((t / HT) % VT);
    hb = (!r && h >= HA) ? 1 : 0;
    hs = (!r && h >= HA + HF && h < HA + HF + HS) ? 1 : 0;
    vb = (!r && v >= VA) ? 1 : 0;
    vs = (!r && v >= VA + VF && v < VA + VF + VS) ? 1 : 0;
    chk("hcount", hcount_out, h);
    chk("vcount", vcount_out, v);
    chk("hsync", hsync_out, hs);
    chk("vsync", vsync_out, vs);
    chk("hblnk", hblnk_out, hb);
    chk("vblnk", vblnk_out, vb);
    chk("x_pointer", x_pointer, mx);
    chk("y_pointer", y_pointer, my);
    chk("frame_start", frame_start, mfs);
    chk("frame_cnt", frame_cnt, mfc);
  endtask

  task automatic rstep();
    bit pv;
    pv = ($urandom_range(0, 7) == 0);
    step(1'b0, pv, int'($urandom_range(0, 2047)), int'($urandom_range(0, 2047)));
  endtask

  task automatic run_until(input int phase, input bit rnd);
    int guard = 0;
    while (t % FRAME != phase && guard <= FRAME) begin
      if (rnd) rstep();
      else step(1'b0, 1'b0, 0, 0);
      guard++;
    end
    chk("phase_reached", t % FRAME, phase);
  endtask

  initial begin
    // valid while in reset must be ignored
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 123, 456);
    chk("rst_hcount", hcount_out, 0);
    chk("rst_x", x_pointer, 0);
    chk("rst_fcnt", frame_cnt, 0);

    step(1'b0, 1'b0, 0, 0);
    chk("first_h", hcount_out, 1);
    for (int i = 0; i < 500; i++) step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 20, 5);
    run_until(FRAME - 1, 1'b0);
    chk("hold_x", x_pointer, 0);
    chk("hold_y", y_pointer, 0);
    chk("no_fs", frame_start, 0);
    step(1'b0, 1'b0, 0, 0);
    chk("load_x", x_pointer, 20);
    chk("load_y", y_pointer, 5);
    chk("fs_pulse", frame_start, 1);
    chk("fcnt_1", frame_cnt, 1);

    for (int i = 0; i < 2 * FRAME; i++) rstep();

    run_until(100, 1'b1);
    step(1'b0, 1'b1, 25, 3);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 0, 0);
    step(1'b0, 1'b1, 15, 2);
    run_until(FRAME - 1, 1'b0);
    step(1'b0, 1'b0, 0, 0);
    chk("last_x", x_pointer, 15);
    chk("last_y", y_pointer, 2);

    run_until(FRAME - 1, 1'b1);
    step(1'b0, 1'b1, 1000, 700);
    chk("clamp_x", x_pointer, XMAX);
    chk("clamp_y", y_pointer, YMAX);

    run_until(10 * HT + 25, 1'b1);
    step(1'b1, 1'b1, 5, 5);
    chk("mid_rst_h", hcount_out, 0);
    chk("mid_rst_v", vcount_out, 0);
    chk("mid_rst_fs", frame_start, 0);
    chk("mid_rst_fcnt", frame_cnt, 0);
    step(1'b0, 1'b0, 0, 0);
    chk("restart_h", hcount_out, 1);
    chk("restart_fs", frame_start, 0);
    for (int i = 0; i < 2 * FRAME; i++) rstep();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter H_ACTIVE, default 800, visible pixels per line.
REQ-002 Parameter H_FP, default 40; H_SYNC, default 128; H_BP, default 88 (H_TOTAL = 1056).
REQ-003 Parameter V_ACTIVE, default 600; V_FP, default 1; V_SYNC, default 4; V_BP, default 23 (V_TOTAL = 628).
REQ-004 Parameter PTR_W, default 10; PTR_H, default 13: pointer rectangle extents used for clamping.
REQ-005 clk  input  1  pixel clock (40 MHz); all logic on rising edge; one clock only.
REQ-006 rst  input  1  reset, synchronous, active-high.
REQ-007 x_pointer_in / y_pointer_in  input  11 each  raw pointer position from the mouse path, clk domain.
REQ-008 ptr_valid  input  1  qualifies x_pointer_in/y_pointer_in this cycle.
REQ-009 hcount_out / vcount_out  output  11 each  current pixel column/line.
REQ-010 hsync_out, vsync_out, hblnk_out, vblnk_out  output  1 each  timing strobes, active-high.
REQ-011 x_pointer / y_pointer  output  11 each  frame-stable, clamped pointer position.
REQ-012 frame_start  output  1  one-cycle pulse at each frame origin.
REQ-013 frame_cnt  output  16  completed-frame counter.

Function
REQ-014 All outputs SHALL be registered; strobes SHALL be consistent with hcount_out/vcount_out in the same cycle (zero relative skew).
REQ-015 hcount_out SHALL increment by 1 per cycle and wrap from H_TOTAL-1 to 0.
REQ-016 vcount_out SHALL increment only in the cycle hcount_out wraps, and wrap from V_TOTAL-1 to 0 in that same cycle.
REQ-017 hblnk_out SHALL be 1 iff hcount_out >= H_ACTIVE (800..1055).
REQ-018 hsync_out SHALL be 1 iff H_ACTIVE+H_FP <= hcount_out < H_ACTIVE+H_FP+H_SYNC (840..967).
REQ-019 vblnk_out SHALL be 1 iff vcount_out >= V_ACTIVE (600..627).
REQ-020 vsync_out SHALL be 1 iff V_ACTIVE+V_FP <= vcount_out < V_ACTIVE+V_FP+V_SYNC (601..604).
REQ-021 A pending pointer register SHALL capture x_pointer_in/y_pointer_in on every cycle with ptr_valid=1.
REQ-022 On the clock edge where counters move to (0,0), x_pointer/y_pointer SHALL load the pending value; if ptr_valid=1 in that cycle, the input value SHALL be used directly.
REQ-023 Loaded values SHALL be clamped: x to at most H_ACTIVE-1-PTR_W (789), y to at most V_ACTIVE-1-PTR_H (586); unsigned, no lower clamp.
REQ-024 x_pointer/y_pointer SHALL NOT change at any other time, regardless of ptr_valid.
REQ-025 frame_start SHALL be 1 exactly in cycles where outputs show (0,0) reached by wrap; never in the cycle immediately after reset.
REQ-026 frame_cnt SHALL increment in the same edge frame_start rises (value visible alongside the pulse), wrapping 65535 -> 0.
REQ-027 Frame period SHALL be H_TOTAL*V_TOTAL = 663168 cycles; line period 1056 cycles.

Reset
REQ-028 While rst=1: hcount_out=0, vcount_out=0, all strobes 0, x_pointer=0, y_pointer=0, pending register=0, frame_start=0, frame_cnt=0.
REQ-029 Reset asserted mid-frame SHALL take effect on the next edge; counting restarts from (0,0) on the first cycle after release (hcount_out=1 then).
REQ-030 ptr_valid during reset SHALL be ignored.

Verification
REQ-031 Release reset, run 1056 cycles -> hcount_out 0..1055 then 0, vcount_out 0->1 at wrap; hsync_out high exactly for hcount 840..967, hblnk_out for 800..1055.
REQ-032 Run one full frame -> vsync_out high lines 601..604 only, vblnk_out lines 600..627; frame_start single pulse at cycle 663168 with frame_cnt=1.
REQ-033 ptr_valid with (400,300) mid-frame -> x_pointer/y_pointer stay 0 until next (0,0), then 400/300.
REQ-034 ptr_valid with (1000,700) in last cycle before (0,0) -> x_pointer=789, y_pointer=586 at frame start.
REQ-035 Two valids (100,100) then (200,50) in one frame -> only (200,50) loaded at frame start.
REQ-036 Assert rst at hcount=500, vcount=300 for one cycle -> all outputs 0 next cycle; no frame_start; frame_cnt=0.
